// File: rtl/l15_anycoredecoder_pkg.sv
// Shared encodings for the AnyCore <-> L1.5 transducer: request types,
// size codes, slot indices and small helpers. The response encoder uses it too.
package anycore_l15_pkg;

  localparam logic [4:0] RQTYPE_IMISS = 5'b10000;
  localparam logic [4:0] RQTYPE_LOAD  = 5'b00000;
  localparam logic [4:0] RQTYPE_STORE = 5'b00001;

  localparam logic [2:0] SIZE_32B = 3'b110;
  localparam logic [2:0] SIZE_16B = 3'b101;

  localparam int NUM_SLOTS = 3;
  localparam logic [1:0] SLOT_IC = 2'd0;
  localparam logic [1:0] SLOT_LD = 2'd1;
  localparam logic [1:0] SLOT_ST = 2'd2;

  typedef enum logic {
    DEC_IDLE,
    DEC_ISSUE
  } dec_state_e;

  // Core stores little-endian bytes; L1.5 expects the reverse order.
  function automatic logic [63:0] byte_rev(input logic [63:0] d);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = d[8*(7-i) +: 8];
    return r;
  endfunction

  function automatic logic [1:0] oh2idx(input logic [2:0] oh);
    return oh[2] ? SLOT_ST : (oh[1] ? SLOT_LD : SLOT_IC);
  endfunction

endpackage

// File: rtl/l15_anycoredecoder_if.sv
// Request bus from the decoder to the L1.5 plus its accept strobe.
interface l15_anycoredecoder_if;
  logic        transducer_l15_val;
  logic [4:0]  transducer_l15_rqtype;
  logic        transducer_l15_nc;
  logic [2:0]  transducer_l15_size;
  logic [39:0] transducer_l15_address;
  logic [63:0] transducer_l15_data;
  logic        transducer_l15_threadid;
  logic        l15_transducer_ack;

  modport master (
    output transducer_l15_val, transducer_l15_rqtype, transducer_l15_nc,
           transducer_l15_size, transducer_l15_address, transducer_l15_data,
           transducer_l15_threadid,
    input  l15_transducer_ack
  );

  modport slave (
    input  transducer_l15_val, transducer_l15_rqtype, transducer_l15_nc,
           transducer_l15_size, transducer_l15_address, transducer_l15_data,
           transducer_l15_threadid,
    output l15_transducer_ack
  );
endinterface

// File: rtl/l15_anycoredecoder_arb.sv
// Three-way round-robin arbiter: priority starts just after the last grant.
module anycore_rr_arb3
  import anycore_l15_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [2:0] gnt
);

  // Walk the sources in rotating order; the first requester found wins.
  always_comb begin
    gnt = '0;
    for (int k = 1; k <= NUM_SLOTS; k++) begin
      int idx;
      idx = (int'(last) + k) % NUM_SLOTS;
      if (gnt == '0 && req[idx]) gnt[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/l15_anycoredecoder.sv
// Collects IFILL/LOAD/STORE requests from the AnyCore caches into one slot
// per source and presents them one at a time to the L1.5.
module l15_anycoredecoder
  import anycore_l15_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 anycore_ic2mem_reqvalid,
  input  logic [63:0]          anycore_ic2mem_reqaddr,
  input  logic                 anycore_dc2mem_ldvalid,
  input  logic [63:0]          anycore_dc2mem_ldaddr,
  input  logic                 anycore_dc2mem_stvalid,
  input  logic [63:0]          anycore_dc2mem_staddr,
  input  logic [63:0]          anycore_dc2mem_stdata,
  input  logic [1:0]           anycore_dc2mem_stsize,
  l15_anycoredecoder_if.master l15,
  output logic                 decoder_ic_busy,
  output logic                 decoder_ld_busy,
  output logic                 decoder_st_busy,
  output logic                 decoder_overflow
);

  dec_state_e  state_reg, state_next;
  logic [2:0]  sel_reg, sel_next;
  logic [1:0]  last_reg, last_next;
  logic [2:0]  slot_v_reg, slot_v_next;
  logic [39:0] slot_addr_reg [NUM_SLOTS];
  logic [63:0] st_data_reg;
  logic [1:0]  st_size_reg;
  logic        overflow_reg, overflow_next;

  logic [2:0]  in_v, freeing, capture, drop, arb_req, gnt;
  logic [39:0] in_addr [NUM_SLOTS];
  logic [39:0] sel_addr;
  logic [1:0]  sel_idx;
  logic        unused_addr_bits;

  assign in_v = {anycore_dc2mem_stvalid, anycore_dc2mem_ldvalid, anycore_ic2mem_reqvalid};
  assign in_addr[SLOT_IC] = {anycore_ic2mem_reqaddr[39:5], 5'b0};
  assign in_addr[SLOT_LD] = {anycore_dc2mem_ldaddr[39:4], 4'b0};
  assign in_addr[SLOT_ST] = anycore_dc2mem_staddr[39:0];
  assign unused_addr_bits = ^{anycore_ic2mem_reqaddr[63:40], anycore_ic2mem_reqaddr[4:0],
                              anycore_dc2mem_ldaddr[63:40], anycore_dc2mem_ldaddr[3:0],
                              anycore_dc2mem_staddr[63:40]};

  // Only the selected slot can be freed, and only by an ack while issuing.
  assign freeing = (state_reg == DEC_ISSUE && l15.l15_transducer_ack) ? sel_reg : 3'b000;

  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      assign capture[gi]     = in_v[gi] && (!slot_v_reg[gi] || freeing[gi]);
      assign drop[gi]        = in_v[gi] && slot_v_reg[gi] && !freeing[gi];
      assign slot_v_next[gi] = capture[gi] || (slot_v_reg[gi] && !freeing[gi]);
    end
  endgenerate

  assign overflow_next = overflow_reg || (|drop);

  // While issuing, the follow-on winner is picked from next cycle's slot state.
  assign arb_req = (state_reg == DEC_ISSUE) ? slot_v_next : slot_v_reg;

  anycore_rr_arb3 u_arb (
    .req  (arb_req),
    .last (last_reg),
    .gnt  (gnt)
  );

  // Next-state logic: select on entry to ISSUE, hold selection until ack.
  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    last_next  = last_reg;
    unique case (state_reg)
      DEC_IDLE: begin
        if (|slot_v_reg) begin
          state_next = DEC_ISSUE;
          sel_next   = gnt;
          last_next  = oh2idx(gnt);
        end
      end
      DEC_ISSUE: begin
        if (l15.l15_transducer_ack) begin
          if (|slot_v_next) begin
            sel_next  = gnt;
            last_next = oh2idx(gnt);
          end else begin
            state_next = DEC_IDLE;
            sel_next   = '0;
          end
        end
      end
      default: state_next = DEC_IDLE;
    endcase
  end

  assign sel_idx  = oh2idx(sel_reg);
  assign sel_addr = slot_addr_reg[sel_idx];

  // Request bus decode: everything is zero unless a request is being issued.
  always_comb begin
    l15.transducer_l15_val      = 1'b0;
    l15.transducer_l15_rqtype   = '0;
    l15.transducer_l15_nc       = 1'b0;
    l15.transducer_l15_size     = '0;
    l15.transducer_l15_address  = '0;
    l15.transducer_l15_data     = '0;
    l15.transducer_l15_threadid = 1'b0;
    if (state_reg == DEC_ISSUE) begin
      l15.transducer_l15_val     = 1'b1;
      l15.transducer_l15_address = sel_addr;
      l15.transducer_l15_nc      = sel_addr[39];
      unique case (sel_idx)
        SLOT_IC: begin
          l15.transducer_l15_rqtype = RQTYPE_IMISS;
          l15.transducer_l15_size   = SIZE_32B;
        end
        SLOT_LD: begin
          l15.transducer_l15_rqtype = RQTYPE_LOAD;
          l15.transducer_l15_size   = SIZE_16B;
        end
        default: begin
          l15.transducer_l15_rqtype = RQTYPE_STORE;
          l15.transducer_l15_size   = {1'b0, st_size_reg} + 3'd1;
          l15.transducer_l15_data   = byte_rev(st_data_reg);
        end
      endcase
    end
  end

  // State, slot storage and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= DEC_IDLE;
      sel_reg      <= '0;
      last_reg     <= SLOT_ST;
      slot_v_reg   <= '0;
      overflow_reg <= 1'b0;
      st_data_reg  <= '0;
      st_size_reg  <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) slot_addr_reg[i] <= '0;
    end else begin
      state_reg    <= state_next;
      sel_reg      <= sel_next;
      last_reg     <= last_next;
      slot_v_reg   <= slot_v_next;
      overflow_reg <= overflow_next;
      for (int i = 0; i < NUM_SLOTS; i++)
        if (capture[i]) slot_addr_reg[i] <= in_addr[i];
      if (capture[SLOT_ST]) begin
        st_data_reg <= anycore_dc2mem_stdata;
        st_size_reg <= anycore_dc2mem_stsize;
      end
    end
  end

  assign decoder_ic_busy  = slot_v_reg[SLOT_IC];
  assign decoder_ld_busy  = slot_v_reg[SLOT_LD];
  assign decoder_st_busy  = slot_v_reg[SLOT_ST];
  assign decoder_overflow = overflow_reg;

endmodule

// File: tb/tb_l15_anycoredecoder.sv
// Directed bench for the AnyCore -> L1.5 request decoder.
module tb_l15_anycoredecoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ic_v = 1'b0;
  logic [63:0] ic_addr = '0;
  logic        ld_v = 1'b0;
  logic [63:0] ld_addr = '0;
  logic        st_v = 1'b0;
  logic [63:0] st_addr = '0;
  logic [63:0] st_data = '0;
  logic [1:0]  st_size = '0;
  logic        ic_busy, ld_busy, st_busy, overflow;

  int n_chk = 0;
  int n_fail = 0;

  l15_anycoredecoder_if bus();

  l15_anycoredecoder dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .anycore_ic2mem_reqvalid (ic_v),
    .anycore_ic2mem_reqaddr  (ic_addr),
    .anycore_dc2mem_ldvalid  (ld_v),
    .anycore_dc2mem_ldaddr   (ld_addr),
    .anycore_dc2mem_stvalid  (st_v),
    .anycore_dc2mem_staddr   (st_addr),
    .anycore_dc2mem_stdata   (st_data),
    .anycore_dc2mem_stsize   (st_size),
    .l15                     (bus),
    .decoder_ic_busy         (ic_busy),
    .decoder_ld_busy         (ld_busy),
    .decoder_st_busy         (st_busy),
    .decoder_overflow        (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic show_txn(input string tag);
    $display("%s: val=%b rqtype=%b size=%b nc=%b addr=%h data=%h", tag,
             bus.transducer_l15_val, bus.transducer_l15_rqtype, bus.transducer_l15_size,
             bus.transducer_l15_nc, bus.transducer_l15_address, bus.transducer_l15_data);
  endtask

  task automatic test_reset();
    bus.l15_transducer_ack = 1'b0;
    #2 rst_n = 1'b0;
    cyc();
    cyc();
    @(negedge clk);
    n_chk++;
    if (bus.transducer_l15_val !== 1'b0) begin
      n_fail++; $display("FAIL reset_val: got %b want 0", bus.transducer_l15_val);
    end
    n_chk++;
    if ({bus.transducer_l15_rqtype, bus.transducer_l15_size, bus.transducer_l15_nc,
         bus.transducer_l15_address, bus.transducer_l15_data, bus.transducer_l15_threadid} !== '0) begin
      n_fail++; $display("FAIL reset_bus: addr=%h data=%h want all zero",
                         bus.transducer_l15_address, bus.transducer_l15_data);
    end
    n_chk++;
    if ({ic_busy, ld_busy, st_busy} !== 3'b000) begin
      n_fail++; $display("FAIL reset_busy: got %b want 000", {ic_busy, ld_busy, st_busy});
    end
    n_chk++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow);
    end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_ifill();
    logic [39:0] exp_addr;
    exp_addr = 40'h80_0000_1220;
    ic_v = 1'b1;
    ic_addr = 64'hFFFF_FF80_0000_1234;
    cyc();
    ic_v = 1'b0;
    @(negedge clk);
    n_chk++;
    if (ic_busy !== 1'b1 || bus.transducer_l15_val !== 1'b0) begin
      n_fail++; $display("FAIL ifill_capture: busy=%b val=%b want busy=1 val=0",
                         ic_busy, bus.transducer_l15_val);
    end
    cyc();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) bus.l15_transducer_ack = 1'b1;
      @(negedge clk);
      show_txn("ifill");
      n_chk++;
      if (bus.transducer_l15_val !== 1'b1 || bus.transducer_l15_address !== exp_addr) begin
        n_fail++; $display("FAIL ifill_hold%0d: val=%b addr=%h want val=1 addr=%h",
                           i, bus.transducer_l15_val, bus.transducer_l15_address, exp_addr);
      end
      if (i == 0) begin
        n_chk++;
        if (bus.transducer_l15_rqtype !== 5'b10000 || bus.transducer_l15_size !== 3'b110) begin
          n_fail++; $display("FAIL ifill_type: rqtype=%b size=%b want 10000 110",
                             bus.transducer_l15_rqtype, bus.transducer_l15_size);
        end
        n_chk++;
        if (bus.transducer_l15_nc !== 1'b1 || bus.transducer_l15_data !== 64'h0 ||
            bus.transducer_l15_threadid !== 1'b0) begin
          n_fail++; $display("FAIL ifill_nc_data: nc=%b data=%h tid=%b want 1 0 0",
                             bus.transducer_l15_nc, bus.transducer_l15_data,
                             bus.transducer_l15_threadid);
        end
      end
      cyc();
    end
    bus.l15_transducer_ack = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.transducer_l15_val !== 1'b0 || ic_busy !== 1'b0) begin
      n_fail++; $display("FAIL ifill_done: val=%b busy=%b want 0 0", bus.transducer_l15_val, ic_busy);
    end
  endtask

  task automatic test_store();
    st_v = 1'b1;
    st_addr = 64'h1008;
    st_data = 64'h0102030405060708;
    st_size = 2'd2;
    cyc();
    st_v = 1'b0;
    cyc();
    @(negedge clk);
    show_txn("store");
    n_chk++;
    if (bus.transducer_l15_val !== 1'b1 || bus.transducer_l15_rqtype !== 5'b00001 ||
        bus.transducer_l15_size !== 3'b011) begin
      n_fail++; $display("FAIL store_type: val=%b rqtype=%b size=%b want 1 00001 011",
                         bus.transducer_l15_val, bus.transducer_l15_rqtype, bus.transducer_l15_size);
    end
    n_chk++;
    if (bus.transducer_l15_data !== 64'h0807060504030201 || bus.transducer_l15_address !== 40'h1008 ||
        bus.transducer_l15_nc !== 1'b0) begin
      n_fail++; $display("FAIL store_data: data=%h addr=%h nc=%b want 0807060504030201 1008 0",
                         bus.transducer_l15_data, bus.transducer_l15_address, bus.transducer_l15_nc);
    end
    bus.l15_transducer_ack = 1'b1;
    cyc();
    bus.l15_transducer_ack = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.transducer_l15_val !== 1'b0 || st_busy !== 1'b0) begin
      n_fail++; $display("FAIL store_done: val=%b busy=%b want 0 0", bus.transducer_l15_val, st_busy);
    end
  endtask

  task automatic test_three_way();
    logic [4:0]  exp_type [3];
    logic [39:0] exp_addr [3];
    exp_type[0] = 5'b10000; exp_addr[0] = 40'h2000_0040;
    exp_type[1] = 5'b00000; exp_addr[1] = 40'h3000;
    exp_type[2] = 5'b00001; exp_addr[2] = 40'h4004;
    ic_v = 1'b1; ic_addr = 64'h2000_0040;
    ld_v = 1'b1; ld_addr = 64'h3008;
    st_v = 1'b1; st_addr = 64'h4004; st_data = 64'hAA; st_size = 2'd0;
    cyc();
    ic_v = 1'b0; ld_v = 1'b0; st_v = 1'b0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      show_txn("rr");
      n_chk++;
      if (bus.transducer_l15_val !== 1'b1 || bus.transducer_l15_rqtype !== exp_type[i] ||
          bus.transducer_l15_address !== exp_addr[i]) begin
        n_fail++; $display("FAIL rr_order%0d: val=%b rqtype=%b addr=%h want 1 %b %h", i,
                           bus.transducer_l15_val, bus.transducer_l15_rqtype,
                           bus.transducer_l15_address, exp_type[i], exp_addr[i]);
      end
      bus.l15_transducer_ack = 1'b1;
      cyc();
      bus.l15_transducer_ack = 1'b0;
    end
    @(negedge clk);
    n_chk++;
    if (bus.transducer_l15_val !== 1'b0 || {ic_busy, ld_busy, st_busy} !== 3'b000) begin
      n_fail++; $display("FAIL rr_done: val=%b busy=%b want 0 000",
                         bus.transducer_l15_val, {ic_busy, ld_busy, st_busy});
    end
  endtask

  task automatic test_overflow();
    ld_v = 1'b1;
    ld_addr = 64'h5010;
    cyc();
    ld_addr = 64'h6020;
    cyc();
    ld_v = 1'b0;
    @(negedge clk);
    show_txn("ovf");
    n_chk++;
    if (overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow);
    end
    n_chk++;
    if (bus.transducer_l15_val !== 1'b1 || bus.transducer_l15_rqtype !== 5'b00000 ||
        bus.transducer_l15_address !== 40'h5010 || bus.transducer_l15_size !== 3'b101) begin
      n_fail++; $display("FAIL ovf_first: val=%b rqtype=%b addr=%h size=%b want 1 00000 5010 101",
                         bus.transducer_l15_val, bus.transducer_l15_rqtype,
                         bus.transducer_l15_address, bus.transducer_l15_size);
    end
    bus.l15_transducer_ack = 1'b1;
    cyc();
    bus.l15_transducer_ack = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.transducer_l15_val !== 1'b0 || ld_busy !== 1'b0 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_after: val=%b busy=%b ovf=%b want 0 0 1",
                         bus.transducer_l15_val, ld_busy, overflow);
    end
  endtask

  task automatic test_reset_mid_issue();
    ld_v = 1'b1;
    ld_addr = 64'h7000;
    cyc();
    ld_v = 1'b0;
    cyc();
    @(negedge clk);
    n_chk++;
    if (bus.transducer_l15_val !== 1'b1) begin
      n_fail++; $display("FAIL rst_issue_pre: val=%b want 1", bus.transducer_l15_val);
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (bus.transducer_l15_val !== 1'b0 || ld_busy !== 1'b0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL rst_issue_async: val=%b busy=%b ovf=%b want 0 0 0",
                         bus.transducer_l15_val, ld_busy, overflow);
    end
    cyc();
    cyc();
    rst_n = 1'b1;
    bus.l15_transducer_ack = 1'b1;
    cyc();
    bus.l15_transducer_ack = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.transducer_l15_val !== 1'b0 || {ic_busy, ld_busy, st_busy} !== 3'b000) begin
      n_fail++; $display("FAIL rst_issue_stray_ack: val=%b busy=%b want 0 000",
                         bus.transducer_l15_val, {ic_busy, ld_busy, st_busy});
    end
  endtask

  task automatic test_back_to_back();
    ld_v = 1'b1;
    ld_addr = 64'h8000;
    cyc();
    ld_v = 1'b0;
    cyc();
    @(negedge clk);
    show_txn("b2b_first");
    n_chk++;
    if (bus.transducer_l15_val !== 1'b1 || bus.transducer_l15_address !== 40'h8000) begin
      n_fail++; $display("FAIL b2b_first: val=%b addr=%h want 1 8000",
                         bus.transducer_l15_val, bus.transducer_l15_address);
    end
    bus.l15_transducer_ack = 1'b1;
    ld_v = 1'b1;
    ld_addr = 64'h9000;
    cyc();
    bus.l15_transducer_ack = 1'b0;
    ld_v = 1'b0;
    @(negedge clk);
    show_txn("b2b_second");
    n_chk++;
    if (bus.transducer_l15_val !== 1'b1 || bus.transducer_l15_address !== 40'h9000 ||
        bus.transducer_l15_rqtype !== 5'b00000) begin
      n_fail++; $display("FAIL b2b_second: val=%b addr=%h rqtype=%b want 1 9000 00000",
                         bus.transducer_l15_val, bus.transducer_l15_address,
                         bus.transducer_l15_rqtype);
    end
    n_chk++;
    if (overflow !== 1'b0 || ld_busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_flags: ovf=%b busy=%b want 0 1", overflow, ld_busy);
    end
    bus.l15_transducer_ack = 1'b1;
    cyc();
    bus.l15_transducer_ack = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.transducer_l15_val !== 1'b0 || ld_busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_done: val=%b busy=%b want 0 0", bus.transducer_l15_val, ld_busy);
    end
  endtask

  initial begin
    bus.l15_transducer_ack = 1'b0;
    test_reset();
    test_ifill();
    test_store();
    test_three_way();
    test_overflow();
    test_reset_mid_issue();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/l15_anycoredecoder.md
L15_ANYCOREDECODER -- requirements
Module: l15_anycoredecoder

Interface
REQ-001 SHALL have ports clk (in, 1, sole clock, rising edge) and rst_n (in, 1, asynchronous active-low reset); one clock, reset asynchronous and active-low.
REQ-002 SHALL accept core-side inputs: anycore_ic2mem_reqvalid (1, ifill request pulse), anycore_ic2mem_reqaddr (64, sign-extended byte address), anycore_dc2mem_ldvalid (1), anycore_dc2mem_ldaddr (64), anycore_dc2mem_stvalid (1), anycore_dc2mem_staddr (64), anycore_dc2mem_stdata (64, core byte order), anycore_dc2mem_stsize (2: 0=1B, 1=2B, 2=4B, 3=8B).
REQ-003 SHALL drive L1.5-side outputs: transducer_l15_val (1), transducer_l15_rqtype (5), transducer_l15_nc (1), transducer_l15_size (3), transducer_l15_address (40), transducer_l15_data (64), transducer_l15_threadid (1, tied 0).
REQ-004 SHALL accept l15_transducer_ack (in, 1): L1.5 accepted the presented request this cycle.
REQ-005 SHALL drive status outputs: decoder_ic_busy, decoder_ld_busy, decoder_st_busy (1 each, slot pending), decoder_overflow (1, sticky).

Function
REQ-006 SHALL hold one pending slot per source (IFILL, LOAD, STORE), each storing valid bit, 40-bit address, and for STORE data and size.
REQ-007 SHALL capture a source's request into its empty slot on the cycle its valid input is high; slot becomes valid the next cycle.
REQ-008 SHALL, when a valid input arrives while its slot is already valid and not being freed that cycle, drop the request and set decoder_overflow until reset.
REQ-009 SHALL, when a slot is freed by ack in the same cycle its source's valid is high, capture the new request (no overflow).
REQ-010 SHALL truncate addresses to bits [39:0]; IFILL address forced 32-byte aligned ([4:0]=0), LOAD address forced 16-byte aligned ([3:0]=0), STORE address unmodified.
REQ-011 SHALL encode rqtype IMISS=5'b10000, LOAD=5'b00000, STORE=5'b00001; size IFILL=3'b110 (32B), LOAD=3'b101 (16B), STORE=stsize+1 (3'b001..3'b100).
REQ-012 SHALL drive transducer_l15_nc=1 when address bit 39 is 1, else 0.
REQ-013 SHALL byte-reverse STORE data (byte0<->byte7, etc.) onto transducer_l15_data; data SHALL be 0 for IFILL/LOAD.
REQ-014 SHALL use a two-state FSM: IDLE (val=0) and ISSUE (val=1, one slot selected).
REQ-015 IDLE->ISSUE on the cycle after any slot is valid; selection made on entry and frozen for the duration of ISSUE.
REQ-016 In ISSUE all transducer_l15_* outputs SHALL remain stable until l15_transducer_ack=1.
REQ-017 On ack: selected slot cleared; FSM goes to ISSUE with the next winner if another slot is valid next cycle, else IDLE (one request per ack, no back-to-back on same cycle).
REQ-018 Selection SHALL be round-robin over order IFILL->LOAD->STORE, starting after the last granted source; after reset the STORE source counts as last granted (IFILL has first priority).
REQ-019 decoder_*_busy SHALL equal the corresponding slot valid bit.
REQ-020 Ack received in IDLE SHALL be ignored.

Reset
REQ-021 On rst_n low, asynchronously: all slots invalid, FSM=IDLE, transducer_l15_val=0, all other transducer outputs 0, busy outputs 0, decoder_overflow=0, round-robin pointer=STORE.
REQ-022 Reset mid-ISSUE SHALL abandon the request without waiting for ack; a later stray ack SHALL be ignored per REQ-020.

Structure
REQ-023 Rqtype and size codes and slot index constants SHALL reside in shared package anycore_l15_pkg, used also by the response encoder.
REQ-024 Round-robin selection SHALL be sub-module anycore_rr_arb3 (3 requests, last-grant pointer input, one-hot grant output).

Verification
REQ-025 IFILL at 0xFFFF_FF80_0000_1234, ack after 3 cycles -> val held 3 cycles, rqtype 10000, size 110, address 0x80_0000_1220, nc=1, then IDLE.
REQ-026 STORE addr 0x1008, data 0x0102030405060708, stsize 2 -> rqtype 00001, size 011, data 0x0807060504030201, nc=0.
REQ-027 IFILL, LOAD, STORE valid same cycle, immediate acks -> issue order IFILL, LOAD, STORE on consecutive ISSUE phases.
REQ-028 Second LOAD while LOAD slot pending without ack -> decoder_overflow=1, first LOAD still issued unchanged.
REQ-029 rst_n asserted during ISSUE, then ack pulsed -> val=0 immediately, no request issued, all busy=0.
REQ-030 LOAD acked in same cycle new LOAD valid -> new LOAD captured, overflow stays 0, issued next.
